sm3_unpadding: RTL and testbench

- Inverse of the SM3 message padder.
- Accepts one padded 512-bit SM3 block.
- Checks that the padding is well-formed, recovers the bit length from the trailing 64 bits, and streams the original message back out one byte per handshake.
- Used as a loopback checker behind the padder and as the host-side depadder for single-block messages (up to 55 bytes).

---
 rtl/sm3_unpadding.sv | 176 +++++++++++++++++
 tb/tb_sm3_unpadding.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_unpadding.sv
// SM3 single-block depadder: validates the padding of one 512-bit block,
// recovers the message length and streams the message back one byte per handshake.
module sm3_unpadding #(
    parameter bit          CHECK_FILL   = 1'b1,
    parameter int unsigned MAX_LEN_BITS = 440
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:511] block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:7]   out_byte,
    output logic         out_last,
    output logic         done,
    output logic         err,
    output logic [0:1]   err_code,
    output logic [0:63]  msg_len
);

    localparam int unsigned MSG_W = 448;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned IDX_W = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_STREAM
    } state_t;

    state_t             r_state, w_state_nx;
    logic [MSG_W-1:0]   r_block, w_block_nx;
    logic [63:0]        r_msg_len, w_msg_len_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]   r_last_idx, w_last_idx_nx;
    logic [7:0]         r_out_byte, w_out_byte_nx;
    logic               r_out_valid, w_out_valid_nx;
    logic               r_out_last, w_out_last_nx;
    logic               r_done, w_done_nx;
    logic               r_err, w_err_nx;
    logic [1:0]         r_err_code, w_err_code_nx;
    logic               r_in_ready, w_in_ready_nx;

    logic [MSG_W-1:0]   w_shifted;
    logic               w_too_long;
    logic               w_misaligned;
    logic               w_bad_pad;
    logic [CNT_W-1:0]   w_nbytes;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [IDX_W-1:0]   w_byte_msb;

    // Shifting by L brings the marker byte to the top; everything below it is fill.
    assign w_shifted    = r_block << r_msg_len[IDX_W-1:0];
    assign w_too_long   = r_msg_len > 64'(MAX_LEN_BITS);
    assign w_misaligned = r_msg_len[2:0] != 3'd0;
    assign w_bad_pad    = (w_shifted[MSG_W-1 -: 8] != 8'h80) ||
                          (CHECK_FILL && (|w_shifted[MSG_W-9:0]));
    assign w_nbytes     = r_msg_len[IDX_W-1:3];
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_byte_msb   = IDX_W'(MSG_W - 1) - {w_cnt_inc, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_block_nx     = r_block;
        w_msg_len_nx   = r_msg_len;
        w_cnt_nx       = r_cnt;
        w_last_idx_nx  = r_last_idx;
        w_out_byte_nx  = r_out_byte;
        w_out_valid_nx = r_out_valid;
        w_out_last_nx  = r_out_last;
        w_done_nx      = 1'b0;
        w_err_nx       = 1'b0;
        w_err_code_nx  = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_block_nx    = block[0:MSG_W-1];
                    w_msg_len_nx  = block[448:511];
                    w_err_code_nx = 2'b00;
                    w_cnt_nx      = '0;
                    w_state_nx    = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nx = S_IDLE;
                if (w_too_long) begin
                    w_err_code_nx = 2'b10;
                    w_err_nx      = 1'b1;
                end else if (w_misaligned) begin
                    w_err_code_nx = 2'b01;
                    w_err_nx      = 1'b1;
                end else if (w_bad_pad) begin
                    w_err_code_nx = 2'b11;
                    w_err_nx      = 1'b1;
                end else if (w_nbytes == '0) begin
                    w_done_nx = 1'b1;
                end else begin
                    w_state_nx     = S_STREAM;
                    w_out_valid_nx = 1'b1;
                    w_out_byte_nx  = r_block[MSG_W-1 -: 8];
                    w_cnt_nx       = '0;
                    w_last_idx_nx  = w_nbytes - CNT_W'(1);
                    w_out_last_nx  = (w_nbytes == CNT_W'(1));
                end
            end
            S_STREAM: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        w_out_valid_nx = 1'b0;
                        w_out_last_nx  = 1'b0;
                        w_done_nx      = 1'b1;
                        w_state_nx     = S_IDLE;
                    end else begin
                        w_cnt_nx      = w_cnt_inc;
                        w_out_byte_nx = r_block[w_byte_msb -: 8];
                        w_out_last_nx = (w_cnt_inc == r_last_idx);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_in_ready_nx = (w_state_nx == S_IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block     <= '0;
            r_msg_len   <= '0;
            r_cnt       <= '0;
            r_last_idx  <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_in_ready  <= 1'b0;
        end else begin
            r_block     <= w_block_nx;
            r_msg_len   <= w_msg_len_nx;
            r_cnt       <= w_cnt_nx;
            r_last_idx  <= w_last_idx_nx;
            r_out_byte  <= w_out_byte_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_last  <= w_out_last_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_err_code  <= w_err_code_nx;
            r_in_ready  <= w_in_ready_nx;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign msg_len   = r_msg_len;

endmodule

// File: tb/tb_sm3_unpadding.sv
// Scoreboard bench for sm3_unpadding: a byte-level reference model queues the
// expected stream/done/err events; a monitor pops and compares them.
module tb_sm3_unpadding;

    localparam bit          CHECK_FILL   = 1'b1;
    localparam int unsigned MAX_LEN_BITS = 440;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:511] block;
    logic         out_valid;
    logic         out_ready;
    logic [0:7]   out_byte;
    logic         out_last;
    logic         done;
    logic         err;
    logic [0:1]   err_code;
    logic [0:63]  msg_len;

    sm3_unpadding #(
        .CHECK_FILL  (CHECK_FILL),
        .MAX_LEN_BITS(MAX_LEN_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .block    (block),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte (out_byte),
        .out_last (out_last),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .msg_len  (msg_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 byte, 1 done, 2 err
        logic [7:0]  data;
        bit          last;
        logic [1:0]  code;
        logic [63:0] len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          hs_count = 0;
    int          ready_mode = 0;  // 0 always ready, 1 random
    logic [7:0]  bb[64];
    logic [63:0] cur_len;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: byte-oriented reading of the padding rules.
    task automatic model_push();
        exp_t e;
        int   n;
        bit   bad;
        e.data = 8'h00; e.last = 1'b0; e.code = 2'd0; e.len = cur_len;
        if (cur_len > 64'(MAX_LEN_BITS)) begin
            e.kind = 2; e.code = 2'd2; exp_q.push_back(e);
        end else if (cur_len % 8 != 0) begin
            e.kind = 2; e.code = 2'd1; exp_q.push_back(e);
        end else begin
            n   = int'(cur_len / 8);
            bad = (bb[n] != 8'h80);
            if (CHECK_FILL)
                for (int j = n + 1; j < 56; j++) if (bb[j] != 8'h00) bad = 1'b1;
            if (bad) begin
                e.kind = 2; e.code = 2'd3; exp_q.push_back(e);
            end else begin
                for (int k = 0; k < n; k++) begin
                    e.kind = 0; e.data = bb[k]; e.last = (k == n - 1); exp_q.push_back(e);
                end
                e.kind = 1; e.data = 8'h00; e.last = 1'b0; exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [0:511] pack();
        logic [0:511] v;
        for (int i = 0; i < 56; i++) v[8*i +: 8] = bb[i];
        v[448:511] = cur_len;
        return v;
    endfunction

    task automatic clear_bb();
        for (int i = 0; i < 64; i++) bb[i] = 8'h00;
    endtask

    task automatic set_abc();
        clear_bb();
        bb[0] = 8'h61; bb[1] = 8'h62; bb[2] = 8'h63; bb[3] = 8'h80;
        cur_len = 64'd24;
    endtask

    // Start at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic accept(output bit ok);
        ok = 1'b0;
        block = pack();
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk(1'b0, "accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns cycles (T+lat) at which done/err was seen; 0 on timeout.
    task automatic wait_end(output int lat);
        int l;
        bit hit;
        l = 1; hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            l++;
            @(negedge clk);
            if (l == 2) chk(out_valid || done || err, "first_response_latency", 64'({out_valid, done, err}), 64'd1);
            if (done || err) begin hit = 1'b1; break; end
        end
        if (hit) chk(in_ready, "in_ready_at_end", 64'(in_ready), 64'd1);
        else chk(1'b0, "end_timeout", 64'(l), 64'd0);
        lat = hit ? l : 0;
        @(posedge clk); #1;
    endtask

    task automatic run_block(output int lat);
        bit ok;
        model_push();
        accept(ok);
        if (ok) wait_end(lat);
        else lat = 0;
    endtask

    task automatic rand_block(input int mode);
        int n;
        clear_bb();
        n = $urandom_range(0, 55);
        for (int i = 0; i < n; i++) bb[i] = 8'($urandom);
        bb[n] = 8'h80;
        cur_len = 64'(8 * n);
        case (mode)
            1: cur_len = cur_len + 64'($urandom_range(1, 7));
            2: cur_len = ($urandom_range(0, 1) == 0) ? 64'(441 + $urandom_range(0, 2000))
                                                     : {32'($urandom), 32'($urandom)} | 64'h8000_0000_0000_0000;
            3: bb[n] = bb[n] ^ 8'($urandom_range(1, 255));
            4: if (n < 55) bb[$urandom_range(n + 1, 55)] = 8'(1 << $urandom_range(0, 7));
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: pops expected events and checks stall stability.
    initial begin
        exp_t       e;
        bit         stall;
        logic [7:0] s_byte;
        bit         s_last;
        stall = 1'b0; s_byte = 8'h00; s_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (out_valid && in_ready) chk(1'b0, "in_ready_while_streaming", 64'(in_ready), 64'd0);
                if (stall)
                    chk(out_valid && out_byte == s_byte && out_last == s_last, "stall_stable",
                        64'({out_valid, out_last, out_byte}), 64'({1'b1, s_last, s_byte}));
                if (out_valid && out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", 64'(out_byte), 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk(e.kind == 0 && out_byte == e.data && out_last == e.last, "byte",
                            64'({out_last, out_byte}), 64'({e.kind[3:0], 3'b000, e.last, e.data}));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) chk(1'b0, "unexpected_done", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk(e.kind == 1 && err_code == 2'd0 && msg_len == e.len, "done",
                            msg_len, e.len);
                    end
                end
                if (err) begin
                    if (exp_q.size() == 0) chk(1'b0, "unexpected_err", 64'(err_code), 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk(e.kind == 2 && err_code == e.code && msg_len == e.len, "err_code",
                            {msg_len[4:63], 2'b00, err_code}, {e.len[59:0], 2'b00, e.code});
                    end
                end
                stall  = out_valid && !out_ready;
                s_byte = out_byte;
                s_last = out_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;
        int h0;
        rst = 1'b1; in_valid = 1'b0; block = '0; out_ready = 1'b1;
        clear_bb(); cur_len = 64'd0;
        repeat (3) @(negedge clk);
        chk(!in_ready && !out_valid && !out_last && !done && !err, "reset_ctrl",
            64'({in_ready, out_valid, out_last, done, err}), 64'd0);
        chk(err_code == 2'd0 && msg_len == 64'd0 && out_byte == 8'h00, "reset_data",
            msg_len | 64'(out_byte) | 64'(err_code), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk(in_ready, "idle_in_ready", 64'(in_ready), 64'd1);

        // "abc", always ready: done at T+5
        ready_mode = 0;
        set_abc(); run_block(lat);
        chk(lat == 5, "abc_done_latency", 64'(lat), 64'd5);

        // zero length: done at T+2
        clear_bb(); bb[0] = 8'h80; cur_len = 64'd0; run_block(lat);
        chk(lat == 2, "zero_len_latency", 64'(lat), 64'd2);

        // "abc" under backpressure
        ready_mode = 1;
        set_abc(); run_block(lat);
        ready_mode = 0;

        // error cases, each reported at T+2
        set_abc(); cur_len = 64'h19; run_block(lat);
        chk(lat == 2, "err_misaligned_latency", 64'(lat), 64'd2);
        set_abc(); cur_len = 64'd448; run_block(lat);
        chk(lat == 2, "err_too_long_latency", 64'(lat), 64'd2);
        set_abc(); bb[3] = 8'h00; run_block(lat);
        chk(lat == 2, "err_marker_latency", 64'(lat), 64'd2);
        set_abc(); bb[12] = 8'h08; run_block(lat);
        chk(lat == (CHECK_FILL ? 2 : 5), "fill_bit100_latency", 64'(lat), 64'(CHECK_FILL ? 2 : 5));

        // maximum length, then 441 (too long beats misaligned)
        ready_mode = 1;
        clear_bb();
        for (int i = 0; i < 55; i++) bb[i] = 8'(i);
        bb[55] = 8'h80; cur_len = 64'd440; run_block(lat);
        cur_len = 64'd441; run_block(lat);

        // randomized mix
        for (int t = 0; t < 150; t++) begin
            ready_mode = $urandom_range(0, 1);
            rand_block(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
            run_block(lat);
        end

        // reset during a maximum-length stream
        ready_mode = 0;
        clear_bb();
        for (int i = 0; i < 55; i++) bb[i] = 8'(i);
        bb[55] = 8'h80; cur_len = 64'd440;
        model_push();
        h0 = hs_count;
        accept(ok);
        for (int i = 0; i < 200 && hs_count < h0 + 10; i++) @(negedge clk);
        chk(hs_count == h0 + 10, "bytes_before_reset", 64'(hs_count - h0), 64'd10);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk(!out_valid && !done && !err, "reset_abandons_stream", 64'({out_valid, done, err}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk(in_ready, "in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        set_abc(); run_block(lat);
        chk(lat == 5, "abc_after_reset_latency", 64'(lat), 64'd5);

        repeat (3) @(posedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
